// File: rtl/seg_adder_if.sv
// rtl/seg_adder_if.sv - start/busy/done handshake and operand/result bus for seg_adder
interface seg_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic             check_ovf;
  logic             flush;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow_flag;

  modport master (
    output start, sub, check_ovf, flush, operand_1, operand_2,
    input  busy, done, result, carry_out, overflow_flag
  );

  modport slave (
    input  start, sub, check_ovf, flush, operand_1, operand_2,
    output busy, done, result, carry_out, overflow_flag
  );
endinterface

// File: rtl/seg_adder.sv
// rtl/seg_adder.sv - multi-cycle segmented add/subtract unit, one SEG_W slice per clock
// Optional ADDER_SAT_EN: clamp signed results on overflow instead of wrapping.
module seg_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  seg_adder_if.slave bus
);
  localparam int NSEG  = WIDTH / SEG_W;
  localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NSEG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shadow_q;
  logic [CNT_W-1:0] seg_q;
  logic             carry_q;
  logic             chk_q;

  int               base;
  logic [SEG_W-1:0] a_seg;
  logic [SEG_W-1:0] b_seg;
  logic [SEG_W:0]   seg_sum;
  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] final_res;
  logic             seg_ovf;
  logic             accept;

  always_comb begin
    base       = int'(seg_q) * SEG_W;
    a_seg      = a_q[base +: SEG_W];
    b_seg      = b_q[base +: SEG_W];
    seg_sum    = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, carry_q};
    shadow_nxt = shadow_q;
    shadow_nxt[base +: SEG_W] = seg_sum[SEG_W-1:0];
    // b_seg is already inverted for subtract, so one add-style rule covers both ops
    seg_ovf    = chk_q & (a_seg[SEG_W-1] == b_seg[SEG_W-1])
                       & (seg_sum[SEG_W-1] != a_seg[SEG_W-1]);
    final_res  = shadow_nxt;
`ifdef ADDER_SAT_EN
    if (seg_ovf) begin
      final_res = a_seg[SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && bus.start && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      a_q               <= '0;
      b_q               <= '0;
      shadow_q          <= '0;
      seg_q             <= '0;
      carry_q           <= 1'b0;
      chk_q             <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.result        <= '0;
      bus.carry_out     <= 1'b0;
      bus.overflow_flag <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.flush) begin
            state_q  <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            shadow_q <= shadow_nxt;
            carry_q  <= seg_sum[SEG_W];
            seg_q    <= seg_q + CNT_W'(1);
            if (seg_q == LAST_SEG) begin
              state_q           <= DONE;
              seg_q             <= '0;
              bus.busy          <= 1'b0;
              bus.done          <= 1'b1;
              bus.result        <= final_res;
              bus.carry_out     <= seg_sum[SEG_W];
              bus.overflow_flag <= seg_ovf;
            end
          end
        end
        default: begin
          bus.done <= 1'b0;
          if (accept) begin
            state_q  <= RUN;
            a_q      <= bus.operand_1;
            b_q      <= bus.sub ? ~bus.operand_2 : bus.operand_2;
            carry_q  <= bus.sub;
            chk_q    <= bus.check_ovf;
            seg_q    <= '0;
            bus.busy <= 1'b1;
          end else begin
            state_q  <= IDLE;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seg_adder.sv
// tb/tb_seg_adder.sv - scoreboard bench for seg_adder with directed and random operations
module tb_seg_adder;
  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int NSEG  = WIDTH / SEG_W;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   busy_len = 0;
  logic [31:0] last_res = '0;
  exp_t sb[$];

  seg_adder_if #(.WIDTH(WIDTH)) bus();

  seg_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic c, input int acc);
    exp_t   e;
    longint sa, sb_v, ex, ua, ub;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua   = longint'({32'b0, a});
    ub   = longint'({32'b0, b});
    if (s) begin
      e.res = a - b;
      e.c   = (ua >= ub);
      ex    = sa - sb_v;
    end else begin
      e.res = a + b;
      e.c   = (ua + ub) > 64'sd4294967295;
      ex    = sa + sb_v;
    end
    e.o = c && ((ex > 64'sd2147483647) || (ex < -64'sd2147483648));
`ifdef ADDER_SAT_EN
    if (e.o) e.res = (ex > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_len = 0;
    end else begin
      if (bus.done) begin
        check("busy_len", 64'(busy_len), 64'(NSEG));
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", 64'(bus.result), 64'(e.res));
          check("carry_out", 64'(bus.carry_out), 64'(e.c));
          check("overflow_flag", 64'(bus.overflow_flag), 64'(e.o));
          check("latency", 64'(cyc - e.acc), 64'(NSEG));
          last_res = e.res;
        end
      end
      if (bus.busy) busy_len++;
      else busy_len = 0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c, input bit expect_done);
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.sub       = s;
    bus.check_ovf = c;
    bus.start     = 1'b1;
    if (expect_done) sb.push_back(model(a, b, s, c, cyc + 1));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 30);
    if (!bus.done) check("done_timeout", 0, 1);
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c);
    wait_idle();
    issue(a, b, s, c, 1'b1);
    wait_done();
  endtask

  task automatic count_dones(input string name);
    int seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check(name, 64'(seen), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit b2b;
    bus.start = 0; bus.sub = 0; bus.check_ovf = 0; bus.flush = 0;
    bus.operand_1 = '0; bus.operand_2 = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_result", 64'(bus.result), 0);
    check("rst_carry", 64'(bus.carry_out), 0);
    check("rst_ovf", 64'(bus.overflow_flag), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    go(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    go(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    go(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    go(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1);
    go(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
    go(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

    // start during RUN is ignored; start during the done cycle is accepted
    wait_idle();
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0);
    wait_done();
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
    wait_done();

    // flush in the second RUN cycle
    wait_idle();
    issue(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(bus.busy), 0);
    check("flush_result_hold", 64'(bus.result), 64'(last_res));
    count_dones("flush_no_done");

    // start together with flush is not accepted
    wait_idle();
    bus.flush = 1'b1;
    issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", 64'(bus.busy), 0);

    // asynchronous reset mid-RUN
    wait_idle();
    issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_run_busy", 64'(bus.busy), 0);
    check("rst_run_done", 64'(bus.done), 0);
    check("rst_run_result", 64'(bus.result), 0);
    check("rst_run_carry", 64'(bus.carry_out), 0);
    check("rst_run_ovf", 64'(bus.overflow_flag), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    last_res = '0;
    count_dones("rst_no_done");

    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!b2b) wait_idle();
      issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done();
      b2b = 1'($urandom_range(0, 1));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
